// File: rtl/opcode_dispatch.sv
// -----------------------------------------------------------------------------
// opcode_dispatch
//
// Buffered opcode decoder. Binary opcodes arrive over a valid/ready handshake,
// are filtered against LEGAL_MASK and queued in a 2-entry FIFO. The head entry
// is presented downstream both as a binary opcode and as a one-hot strobe, with
// its own valid/ready handshake. Illegal opcodes are consumed but not stored.
// Each one raises a one-cycle err pulse and bumps a saturating counter.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. valid must not depend on ready. in_ready is
// derived only from registered occupancy, so a pop in the FULL cycle does not
// open a same-cycle accept.
//
// Parameters
//   SEL_W       opcode width; one-hot width is 2**SEL_W
//   LEGAL_MASK  bit k = 1 marks opcode k as legal
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    source presents an opcode
//   in_op       binary opcode from the source
//   in_ready    block can accept (occupancy != 2)
//   out_valid   head entry available (occupancy != 0)
//   out_op      head opcode, 0 when out_valid is low
//   out_onehot  1 << out_op when out_valid is high, else 0
//   out_ready   sink consumes the head entry
//   err         one-cycle pulse, cycle after an illegal accept
//   ill_cnt     saturating count of illegal accepts
//   ill_clr     synchronous clear of ill_cnt (wins over an increment)
// -----------------------------------------------------------------------------
module opcode_dispatch #(
  parameter int                  SEL_W      = 3,
  parameter logic [2**SEL_W-1:0] LEGAL_MASK = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SEL_W-1:0]    in_op,
  output logic                in_ready,
  output logic                out_valid,
  output logic [SEL_W-1:0]    out_op,
  output logic [2**SEL_W-1:0] out_onehot,
  input  logic                out_ready,
  output logic                err,
  output logic [7:0]          ill_cnt,
  input  logic                ill_clr
);

  localparam int NUM = 2**SEL_W;

  // Occupancy states; the encoding equals the number of stored entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] mem [2];
  logic             head;
  logic             tail;
  logic             ready_q;
  logic             valid_q;

  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;
  logic             ill_acc;

  assign legal   = LEGAL_MASK[in_op];
  assign accept  = in_valid & ready_q;
  assign push    = accept & legal;
  assign ill_acc = accept & ~legal;
  assign pop     = valid_q & out_ready;

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_op     = valid_q ? mem[head] : '0;
  assign out_onehot = valid_q ? ({{(NUM-1){1'b0}}, 1'b1} << mem[head]) : '0;

  // Occupancy FSM. in_ready / out_valid are registered alongside the state so
  // they are pure flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state   <= ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        ONE: begin
          // Simultaneous push and pop keeps occupancy at one.
          if (push && !pop) begin
            state   <= FULL;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
          end else if (pop && !push) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        FULL: begin
          // ready_q is low here, so push cannot occur.
          if (pop) begin
            state   <= ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
    end else begin
      if (push) begin
        mem[tail] <= in_op;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  // Illegal-opcode reporting. The clear has priority over an increment, but
  // the err pulse is independent of the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      ill_cnt <= 8'h00;
    end else begin
      err <= ill_acc;
      if (ill_clr) begin
        ill_cnt <= 8'h00;
      end else if (ill_acc && (ill_cnt != 8'hFF)) begin
        ill_cnt <= ill_cnt + 8'h01;
      end
    end
  end

endmodule
